button_reader: RTL and testbench



---
 rtl/button_reader.sv | 169 ++++++++++++++++
 tb/tb_button_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_reader.sv
// button_reader: two-flop synchronizer, stability-counter debounce and a
// press-tracking FSM. It produces a clean level, single-cycle press, release
// and long-press pulses, and a wrapping 8-bit press counter.
module button_reader #(
  parameter int unsigned DEBOUNCE_CYCLES   = 32'd27000000 / 32'd100,
  parameter int unsigned LONG_PRESS_CYCLES = 32'd27000000,
  parameter bit          ACTIVE_LOW        = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       btn,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  // Pin level when the button is not pressed.
  localparam logic        IDLE_LEVEL = logic'(ACTIVE_LOW);
  localparam logic [31:0] DB_LAST    = 32'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [31:0] LP_LAST    = 32'(LONG_PRESS_CYCLES - 32'd1);

  logic        sync1_r;
  logic        sync2_r;
  logic        raw_act_s;
  logic        stable_r;
  logic [31:0] db_cnt_r;
  logic [31:0] db_cnt_nxt_s;
  logic        toggle_s;
  logic        rise_s;
  logic        fall_s;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] hold_r;
  logic [31:0] hold_nxt_s;
  logic [7:0]  count_r;
  logic [7:0]  count_nxt_s;
  logic        press_r;
  logic        press_nxt_s;
  logic        release_r;
  logic        release_nxt_s;
  logic        long_r;
  logic        long_nxt_s;

  // Bring the asynchronous pin into sys_clk; reset parks it at the idle level.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      sync1_r <= IDLE_LEVEL;
      sync2_r <= IDLE_LEVEL;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // XOR with the idle level yields an active-high "pressed" sample.
  assign raw_act_s = sync2_r ^ IDLE_LEVEL;

  // Stability counter: a mismatch run of DEBOUNCE_CYCLES cycles flips stable.
  always_comb begin
    db_cnt_nxt_s = 32'd0;
    toggle_s     = 1'b0;
    if (raw_act_s == stable_r) begin
      db_cnt_nxt_s = 32'd0;
    end else if (db_cnt_r == DB_LAST) begin
      db_cnt_nxt_s = 32'd0;
      toggle_s     = 1'b1;
    end else begin
      db_cnt_nxt_s = db_cnt_r + 32'd1;
    end
  end

  // Edge events are taken on the edge that flips stable, so pulses line up with pressed.
  assign rise_s = toggle_s & ~stable_r;
  assign fall_s = toggle_s &  stable_r;

  // Debounce state registers.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      stable_r <= 1'b0;
      db_cnt_r <= 32'd0;
    end else begin
      stable_r <= stable_r ^ toggle_s;
      db_cnt_r <= db_cnt_nxt_s;
    end
  end

  // Press FSM next state and pulse decode; a release beats the long threshold.
  always_comb begin
    state_nxt_s   = state_r;
    hold_nxt_s    = hold_r;
    count_nxt_s   = count_r;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    long_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_nxt_s = ST_HELD;
          press_nxt_s = 1'b1;
          count_nxt_s = count_r + 8'd1;
          hold_nxt_s  = 32'd0;
        end else begin
          hold_nxt_s  = 32'd0;
        end
      end
      ST_HELD: begin
        if (fall_s) begin
          state_nxt_s   = ST_IDLE;
          release_nxt_s = 1'b1;
          hold_nxt_s    = 32'd0;
        end else if (hold_r == LP_LAST) begin
          state_nxt_s = ST_LONG;
          long_nxt_s  = 1'b1;
          hold_nxt_s  = 32'd0;
        end else begin
          hold_nxt_s  = hold_r + 32'd1;
        end
      end
      ST_LONG: begin
        if (fall_s) begin
          state_nxt_s   = ST_IDLE;
          release_nxt_s = 1'b1;
        end else begin
          state_nxt_s   = ST_LONG;
        end
        hold_nxt_s = 32'd0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        hold_nxt_s  = 32'd0;
      end
    endcase
  end

  // FSM state, hold counter, press counter and registered pulses.
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_r   <= ST_IDLE;
      hold_r    <= 32'd0;
      count_r   <= 8'd0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      hold_r    <= hold_nxt_s;
      count_r   <= count_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
      long_r    <= long_nxt_s;
    end
  end

  assign pressed       = stable_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign long_pulse    = long_r;
  assign press_count   = count_r;

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader with DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=10, ACTIVE_LOW=1. A cycle-based reference model
// (sample history window plus event timestamps) predicts every output.
module tb_button_reader;
  localparam int D = 4;
  localparam int L = 10;

  logic       sys_clk = 1'b0;
  logic       sys_reset;
  logic       btn;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit       m_p1, m_p2;
  bit       m_stable, m_pp, m_rp, m_lp;
  bit [7:0] m_cnt;
  bit       seen[$];
  int       edge_n;
  int       press_edge;
  bit       long_done;

  // observation counters
  int       press_seen, release_seen, long_seen;
  int       cnt_hist[3];

  button_reader #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_reset    (sys_reset),
    .btn          (btn),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model, then compare all outputs 1 time unit later.
  task automatic tick();
    bit all_diff;
    @(posedge sys_clk);
    edge_n++;
    m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
    if (sys_reset) begin
      m_p1 = 1'b1; m_p2 = 1'b1;
      seen.delete();
      m_stable = 1'b0; m_cnt = 8'd0; long_done = 1'b1;
    end else begin
      // the debouncer sees the pin as it was two edges ago, active-high
      seen.push_back(!m_p2);
      m_p2 = m_p1;
      m_p1 = btn;
      all_diff = (seen.size() >= D);
      if (all_diff)
        for (int i = seen.size() - D; i < seen.size(); i++)
          if (seen[i] == m_stable) all_diff = 1'b0;
      if (all_diff) begin
        m_stable = !m_stable;
        if (m_stable) begin
          m_pp = 1'b1; m_cnt = m_cnt + 8'd1; press_edge = edge_n; long_done = 1'b0;
        end else begin
          m_rp = 1'b1; long_done = 1'b1;
        end
      end else if (m_stable && !long_done && edge_n == press_edge + L) begin
        m_lp = 1'b1; long_done = 1'b1;
      end
    end
    while (seen.size() > 16) void'(seen.pop_front());
    #1;
    chk("pressed",       pressed,       m_stable);
    chk("press_pulse",   press_pulse,   m_pp);
    chk("release_pulse", release_pulse, m_rp);
    chk("long_pulse",    long_pulse,    m_lp);
    chk("press_count",   press_count,   m_cnt);
    if (press_pulse === 1'b1) begin
      press_seen++;
      cnt_hist[0] = cnt_hist[1];
      cnt_hist[1] = cnt_hist[2];
      cnt_hist[2] = press_count;
    end
    if (release_pulse === 1'b1) release_seen++;
    if (long_pulse === 1'b1) long_seen++;
  endtask

  // Tick until the chosen pulse (0 press, 1 release, 2 long) shows; idx -1 on timeout.
  task automatic wait_pulse(input int which, input int limit, output int idx);
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      tick();
      if ((which == 0 && press_pulse === 1'b1) ||
          (which == 1 && release_pulse === 1'b1) ||
          (which == 2 && long_pulse === 1'b1)) begin
        idx = i;
        break;
      end
    end
  endtask

  // Random chatter around target: runs of target always shorter than D.
  task automatic bounce(input bit target, input int bursts);
    for (int b = 0; b < bursts; b++) begin
      btn = target;
      repeat ($urandom_range(D - 1, 1)) tick();
      btn = !target;
      repeat ($urandom_range(3, 1)) tick();
    end
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int idx, base, n;
    m_p1 = 1'b1; m_p2 = 1'b1; m_stable = 1'b0; m_cnt = 8'd0;
    edge_n = 0; press_edge = 0; long_done = 1'b1;
    press_seen = 0; release_seen = 0; long_seen = 0;
    cnt_hist[0] = 0; cnt_hist[1] = 0; cnt_hist[2] = 0;

    // reset values
    sys_reset = 1'b1; btn = 1'b1;
    repeat (3) tick();
    chk("reset_pressed", pressed, 1'b0);
    chk("reset_count", press_count, 8'd0);

    // first press: btn low from edge 0, pulse after edge 5
    sys_reset = 1'b0; btn = 1'b0;
    wait_pulse(0, 20, idx);
    chk("first_press_edge", idx, 32'd5);
    chk("first_press_count", press_count, 8'd1);

    // long press: long_pulse 10 edges after press, then silence while held
    wait_pulse(2, 30, idx);
    chk("long_edge", idx, 32'(L - 1));
    base = long_seen;
    settle(50);
    chk("no_second_long", long_seen - base, 32'd0);
    btn = 1'b1;
    wait_pulse(1, 20, idx);
    chk("release_edge", idx, 32'd5);
    chk("released_level", pressed, 1'b0);
    settle(6);

    // bounce rejection with the fixed 0,0,0,1 pattern
    base = press_seen;
    repeat (6) begin
      btn = 1'b0; repeat (3) tick();
      btn = 1'b1; tick();
    end
    bounce(1'b0, 8);
    chk("bounce_no_press", press_seen - base, 32'd0);
    btn = 1'b0;
    wait_pulse(0, 20, idx);
    chk("post_bounce_press_edge", idx, 32'd5);
    btn = 1'b1;
    settle(8);

    // collision: debounced fall at exactly P+10, release wins
    base = long_seen;
    btn = 1'b0;
    wait_pulse(0, 20, idx);
    repeat (4) tick();
    btn = 1'b1;
    wait_pulse(1, 20, idx);
    chk("collision_release_edge", idx, 32'd5);
    settle(20);
    chk("collision_no_long", long_seen - base, 32'd0);

    // one edge later: long at P+10, release at P+11
    base = long_seen;
    btn = 1'b0;
    wait_pulse(0, 20, idx);
    repeat (5) tick();
    btn = 1'b1;
    wait_pulse(1, 20, idx);
    chk("late_release_edge", idx, 32'd5);
    chk("late_release_long", long_seen - base, 32'd1);
    settle(8);

    // randomized presses with bouncy edges, checked by the model each cycle
    repeat (30) begin
      bounce(1'b0, $urandom_range(3, 0));
      btn = 1'b0;
      repeat ($urandom_range(30, D + 2)) tick();
      bounce(1'b1, $urandom_range(3, 0));
      btn = 1'b1;
      repeat ($urandom_range(12, D + 2)) tick();
    end

    // counter wrap: 257 clean presses from a fresh reset
    sys_reset = 1'b1; btn = 1'b1; tick();
    sys_reset = 1'b0; settle(4);
    base = press_seen;
    repeat (257) begin
      btn = 1'b0; repeat (6) tick();
      btn = 1'b1; repeat (7) tick();
    end
    chk("wrap_press_total", press_seen - base, 32'd257);
    chk("wrap_hist_255", cnt_hist[0], 32'd255);
    chk("wrap_hist_0",   cnt_hist[1], 32'd0);
    chk("wrap_hist_1",   cnt_hist[2], 32'd1);

    // reset mid-press: no release, new press 6 edges after the reset edge
    btn = 1'b0;
    wait_pulse(0, 20, idx);
    repeat (2) tick();
    sys_reset = 1'b1; tick();
    chk("midreset_pressed", pressed, 1'b0);
    chk("midreset_count", press_count, 8'd0);
    sys_reset = 1'b0;
    base = release_seen;
    n = press_seen;
    wait_pulse(0, 20, idx);
    chk("midreset_press_edge", idx, 32'd5);
    chk("midreset_no_release", release_seen - base, 32'd0);
    chk("midreset_one_press", press_seen - n, 32'd1);
    chk("midreset_count_after", press_count, 8'd1);
    btn = 1'b1;
    settle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
